// File: rtl/sort_pkg.sv
// sort_pkg: shared constants, state encoding and LFSR taps for the sorter companion.
package sort_pkg;
    localparam int DEF_FRAME_LEN = 60;
    localparam int DEF_ROW_LEN = 6;
    localparam int DEF_DW = 8;
    localparam int DEF_TIMEOUT = 255;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with loadable seed; zero seed maps to 8'h01.
module lfsr8
    import sort_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= 8'h01;
        else if (load) q <= (seed == 8'h00) ? 8'h01 : seed;
        else if (en) q <= {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/sort_stream_tx.sv
// sort_stream_tx: streams one pseudo-random frame to the row sorter, then receives
// the sorted result and flags any row that is not non-decreasing.
module sort_stream_tx
    import sort_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int ROW_LEN = DEF_ROW_LEN,
    parameter int DW = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] seed,
    output logic          data_vaild,
    output logic [DW-1:0] data,
    input  logic          vaild,
    input  logic [DW-1:0] sort_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [5:0]    rx_count
);
    state_t state, next_state;
    logic [5:0] tx_cnt;
    logic [7:0] to_cnt;
    logic [DW-1:0] prev;
    logic [7:0] q;
    logic accept, last_tx, last_rx, to_hit, rx_phase;
    assign accept = (state == IDLE) && start;
    assign last_tx = tx_cnt == 6'(FRAME_LEN - 1);
    assign last_rx = rx_count == 6'(FRAME_LEN - 1);
    assign to_hit = !vaild && (to_cnt == 8'(TIMEOUT - 1));
    assign rx_phase = (state == WAIT) || (state == RECV);
    assign busy = state != IDLE;
    assign done = state == DONE;
    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (8'(seed)),
        .en   (state == SEND),
        .q    (q)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? SEND : IDLE;
            SEND:    next_state = last_tx ? WAIT : SEND;
            WAIT:    next_state = vaild ? RECV : to_hit ? DONE : WAIT;
            RECV:    next_state = ((vaild && last_rx) || to_hit) ? DONE : RECV;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    // Row position 0 never compares, so the first byte captured in WAIT needs no special case.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            data_vaild <= 1'b0;
            data <= '0;
            tx_cnt <= 6'd0;
            to_cnt <= 8'd0;
            prev <= '0;
            err <= 1'b0;
            rx_count <= 6'd0;
        end else begin
            data_vaild <= state == SEND;
            tx_cnt <= (state == SEND) ? tx_cnt + 6'd1 : 6'd0;
            if (state == SEND) data <= DW'(q);
            if (accept) begin
                err <= 1'b0;
                rx_count <= 6'd0;
                to_cnt <= 8'd0;
            end
            if (rx_phase && vaild) begin
                prev <= sort_data;
                rx_count <= rx_count + 6'd1;
                to_cnt <= 8'd0;
                if ((rx_count % 6'(ROW_LEN)) != 6'd0 && sort_data < prev) err <= 1'b1;
            end else if (rx_phase && to_hit) err <= 1'b1;
            else if (rx_phase) to_cnt <= to_cnt + 8'd1;
        end
endmodule
